// File: rtl/spi_sample_rx.sv
// Receive end of the FPGA-to-Pi sample link: oversamples sclk/ncs/din in the clk domain,
// deserializes sign-magnitude frames, and presents each good frame in raw and two's-complement form.
module spi_sample_rx #(
    parameter int BITS = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sclk,
    input  logic            din,
    input  logic            ncs,
    output logic [BITS-1:0] sample,
    output logic [BITS:0]   sampleTc,
    output logic            valid,
    output logic            frameErr,
    output logic [7:0]      frameCount
);

    localparam int CNT_W = $clog2(BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BITS + 1);

    typedef enum logic [1:0] {
        S_WAITIDLE = 2'd0,
        S_IDLE     = 2'd1,
        S_RECV     = 2'd2
    } state_t;

    state_t          state_q;

    logic            sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic            ncs_s1_q,  ncs_s2_q,  ncs_s3_q;
    logic            din_s1_q,  din_s2_q,  din_s3_q;

    logic            sclk_rise_q, ncs_rise_q, ncs_fall_q;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BITS-1:0]  shift_q, shift_d;

    logic [BITS-1:0]  sample_q;
    logic [BITS:0]    sample_tc_q;
    logic             valid_q;
    logic             frame_err_q;
    logic [7:0]       frame_count_q;

    function automatic logic [BITS:0] to_tc(input logic [BITS-1:0] sm);
        logic [BITS:0] mag;
        mag = {2'b00, sm[BITS-2:0]};
        // Negative zero naturally maps to 0 because 0 - 0 = 0.
        return sm[BITS-1] ? ((BITS+1)'(0) - mag) : mag;
    endfunction

    // Two-flop synchronizers plus a third copy used as the edge-detect reference.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            ncs_s1_q  <= 1'b0;
            ncs_s2_q  <= 1'b0;
            ncs_s3_q  <= 1'b0;
            din_s1_q  <= 1'b0;
            din_s2_q  <= 1'b0;
            din_s3_q  <= 1'b0;
        end else begin
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            ncs_s1_q  <= ncs;
            ncs_s2_q  <= ncs_s1_q;
            ncs_s3_q  <= ncs_s2_q;
            din_s1_q  <= din;
            din_s2_q  <= din_s1_q;
            din_s3_q  <= din_s2_q;
        end
    end

    // Registered edge strobes; din_s3_q is the data bit aligned with sclk_rise_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_rise_q <= 1'b0;
            ncs_rise_q  <= 1'b0;
            ncs_fall_q  <= 1'b0;
        end else begin
            sclk_rise_q <= sclk_s2_q & ~sclk_s3_q;
            ncs_rise_q  <= ncs_s2_q  & ~ncs_s3_q;
            ncs_fall_q  <= ~ncs_s2_q & ncs_s3_q;
        end
    end

    // Shift/count update, so a coincident ncs rise evaluates the post-shift count.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (sclk_rise_q) begin
            shift_d = {shift_q[BITS-2:0], din_s3_q};
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_WAITIDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            sample_q      <= '0;
            sample_tc_q   <= '0;
            valid_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_WAITIDLE: begin
                    if (ncs_s3_q) begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (ncs_fall_q) begin
                        cnt_q   <= '0;
                        shift_q <= '0;
                        state_q <= S_RECV;
                    end
                end
                S_RECV: begin
                    cnt_q   <= cnt_d;
                    shift_q <= shift_d;
                    if (ncs_rise_q) begin
                        state_q <= S_IDLE;
                        if (cnt_d == CNT_FULL) begin
                            sample_q      <= shift_d;
                            sample_tc_q   <= to_tc(shift_d);
                            valid_q       <= 1'b1;
                            frame_count_q <= frame_count_q + 8'd1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_WAITIDLE;
            endcase
        end
    end

    assign sample     = sample_q;
    assign sampleTc   = sample_tc_q;
    assign valid      = valid_q;
    assign frameErr   = frame_err_q;
    assign frameCount = frame_count_q;

endmodule

// File: tb/tb_spi_sample_rx.sv
// Directed bench for spi_sample_rx: frames are queued as expected results when sent,
// and a negedge monitor pops and compares them whenever valid or frameErr pulses.
`timescale 1ns/1ps
module tb_spi_sample_rx;

    localparam int BITS = 11;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sclk;
    logic            din;
    logic            ncs;
    logic [BITS-1:0] sample;
    logic [BITS:0]   sampleTc;
    logic            valid;
    logic            frameErr;
    logic [7:0]      frameCount;

    spi_sample_rx #(.BITS(BITS)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .sclk       (sclk),
        .din        (din),
        .ncs        (ncs),
        .sample     (sample),
        .sampleTc   (sampleTc),
        .valid      (valid),
        .frameErr   (frameErr),
        .frameCount (frameCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              err;
        logic [BITS-1:0] s;
        logic [BITS:0]   tc;
        logic [7:0]      cnt;
    } exp_t;

    exp_t            sb[$];
    int              n_total = 0;
    int              n_pass  = 0;
    logic [BITS-1:0] m_sample;
    logic [BITS:0]   m_tc;
    logic [7:0]      m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [BITS:0] tc_model(input logic [BITS-1:0] s);
        int mag;
        int v;
        mag = int'(s[BITS-2:0]);
        v   = s[BITS-1] ? ((1 << (BITS + 1)) - mag) % (1 << (BITS + 1)) : mag;
        return (BITS+1)'(v);
    endfunction

    task automatic expect_frame(input logic [15:0] word, input int nbits);
        exp_t e;
        if (nbits == BITS) begin
            m_sample = word[BITS-1:0];
            m_tc     = tc_model(m_sample);
            m_cnt    = m_cnt + 8'd1;
            e.err    = 1'b0;
        end else begin
            e.err    = 1'b1;
        end
        e.s   = m_sample;
        e.tc  = m_tc;
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b, input int ph);
        din = b;
        repeat (ph) @(negedge clk);
        sclk = 1'b1;
        repeat (ph) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic wait_pulse();
        int lat;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (valid || frameErr) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd4);
    endtask

    task automatic send_frame(input logic [15:0] word, input int nbits, input int ph);
        expect_frame(word, nbits);
        @(negedge clk);
        ncs  = 1'b0;
        sclk = 1'b0;
        repeat (ph) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) send_bit(word[i], ph);
        repeat (ph) @(negedge clk);
        ncs = 1'b1;
        wait_pulse();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ncs   = 1'b1;
        sclk  = 1'b0;
        din   = 1'b0;
        m_sample = '0;
        m_tc     = '0;
        m_cnt    = '0;
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic chk_hold(input string tag);
        chk({tag, "_sample"}, 32'(sample), 32'(m_sample));
        chk({tag, "_tc"},     32'(sampleTc), 32'(m_tc));
        chk({tag, "_count"},  32'(frameCount), 32'(m_cnt));
    endtask

    // Scoreboard monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && (valid === 1'b1 || frameErr === 1'b1)) begin
            chk("exclusive", 32'(valid & frameErr), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'({valid, frameErr}), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("valid",      32'(valid),      32'(!e.err));
                chk("frameErr",   32'(frameErr),   32'(e.err));
                chk("sample",     32'(sample),     32'(e.s));
                chk("sampleTc",   32'(sampleTc),   32'(e.tc));
                chk("frameCount", 32'(frameCount), 32'(e.cnt));
            end
        end
    end

    initial begin
        logic [15:0] w;

        // Reset state
        do_reset();
        chk("rst_sample",   32'(sample),     32'd0);
        chk("rst_tc",       32'(sampleTc),   32'd0);
        chk("rst_count",    32'(frameCount), 32'd0);
        chk("rst_valid",    32'(valid),      32'd0);
        chk("rst_frameErr", 32'(frameErr),   32'd0);

        // Negative frame at the transmitter's 32-clk phase
        send_frame(16'h052C, BITS, 32);
        chk("f1_sample", 32'(sample),   32'h52C);
        chk("f1_tc",     32'(sampleTc), 32'hED4);
        chk("f1_count",  32'(frameCount), 32'd1);

        // Max positive, then negative zero
        do_reset();
        send_frame(16'h03FF, BITS, 32);
        chk("f2_tc", 32'(sampleTc), 32'h3FF);
        send_frame(16'h0400, BITS, 32);
        chk("f3_sample", 32'(sample),     32'h400);
        chk("f3_tc",     32'(sampleTc),   32'h000);
        chk("f3_count",  32'(frameCount), 32'd2);

        // Short and long frames are discarded
        send_frame(16'h0055, 7, 8);
        chk_hold("short");
        send_frame(16'h1ABC, 13, 8);
        chk_hold("long");

        // Reset in the middle of a frame with ncs held low
        @(negedge clk);
        ncs  = 1'b0;
        sclk = 1'b0;
        w    = 16'h0555;
        repeat (8) @(negedge clk);
        for (int i = BITS - 1; i >= 6; i--) send_bit(w[i], 8);
        rst_n    = 1'b0;
        m_sample = '0;
        m_tc     = '0;
        m_cnt    = '0;
        repeat (3) @(negedge clk);
        chk_hold("midrst");
        rst_n = 1'b1;
        for (int i = 5; i >= 0; i--) send_bit(w[i], 8);
        repeat (8) @(negedge clk);
        ncs = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_no_pulse", 32'(sb.size()), 32'd0);
        chk_hold("midrst_after");
        send_frame(16'h0005, BITS, 32);
        chk("post_rst_sample", 32'(sample),     32'h005);
        chk("post_rst_count",  32'(frameCount), 32'd1);

        // Back-to-back frames at the minimum phase and gap
        do_reset();
        for (int n = 0; n < 300; n++) begin
            w = 16'($urandom_range(0, 2047));
            send_frame(w, BITS, 4);
        end
        chk("b2b_count", 32'(frameCount), 32'd44);

        // sclk activity while deselected must not disturb anything
        for (int n = 0; n < 10; n++) begin
            din  = 1'($urandom);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        chk_hold("idle_sclk");

        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
